// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit memory port between instruction fetch and the LSU
// using a three-state access FSM with a bounded LSU-priority streak.
module mem_port_arbiter #(
    parameter logic [63:0] PC_START       = 64'h8000_0000,
    parameter int          MAX_LSU_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_if_req,
    input  logic [63:0] i_if_addr,
    output logic        o_if_ready,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_lsu_req,
    input  logic        i_lsu_wen,
    input  logic [63:0] i_lsu_addr,
    input  logic [1:0]  i_lsu_size,
    input  logic [63:0] i_lsu_wdata,
    output logic        o_lsu_ready,
    output logic        o_lsu_rvalid,
    output logic [63:0] o_lsu_rdata,
    output logic        o_mem_en,
    output logic [63:0] o_mem_idx,
    output logic        o_mem_wen,
    output logic [63:0] o_mem_wmask,
    output logic [63:0] o_mem_wdata,
    input  logic [63:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      r_state;
    logic [3:0]  r_streak;
    logic        r_src_lsu;
    logic        r_wen;
    logic [63:0] r_addr;
    logic [1:0]  r_size;
    logic [63:0] r_wdata;
    logic [31:0] r_if_rdata;
    logic [63:0] r_lsu_rdata;
    logic        w_idle, w_access, w_resp, w_store;
    logic        w_sel_lsu, w_sel_if;
    logic [63:0] w_req_addr;
    logic [1:0]  w_req_size;
    logic [2:0]  w_req_off;
    logic [5:0]  w_shift;
    logic [7:0]  w_byte_base, w_byte_mask;
    logic [63:0] w_lane_mask, w_size_mask, w_load_data;
    logic [31:0] w_if_data;
    logic [63:0] w_lsu_data;
    assign w_idle   = r_state == IDLE;
    assign w_access = r_state == ACCESS;
    assign w_resp   = r_state == RESP;
    assign w_store  = w_access & r_src_lsu & r_wen;
    // LSU wins ties until it has taken MAX_LSU_STREAK grants in a row over a waiting fetch
    assign w_sel_lsu = i_lsu_req & (~i_if_req | (r_streak != 4'(MAX_LSU_STREAK)));
    assign w_sel_if  = i_if_req & ~w_sel_lsu;
    assign o_if_ready  = w_idle & w_sel_if;
    assign o_lsu_ready = w_idle & w_sel_lsu;
    assign w_req_addr = w_sel_lsu ? i_lsu_addr : i_if_addr;
    assign w_req_size = w_sel_lsu ? i_lsu_size : 2'd2;
    assign w_req_off  = w_req_size == 2'd3 ? 3'b000 :
                        w_req_size == 2'd2 ? {w_req_addr[2], 2'b00} :
                        w_req_size == 2'd1 ? {w_req_addr[2:1], 1'b0} : w_req_addr[2:0];
    assign w_shift     = {r_addr[2:0], 3'b000};
    assign w_byte_base = r_size == 2'd0 ? 8'h01 : r_size == 2'd1 ? 8'h03 : r_size == 2'd2 ? 8'h0F : 8'hFF;
    assign w_byte_mask = w_byte_base << r_addr[2:0];
    assign w_size_mask = r_size == 2'd0 ? 64'hFF : r_size == 2'd1 ? 64'hFFFF :
                         r_size == 2'd2 ? 64'hFFFF_FFFF : '1;
    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign w_lane_mask[8*k +: 8] = {8{w_byte_mask[k]}};
    end
    assign o_mem_en    = w_access;
    assign o_mem_idx   = w_access ? (r_addr - PC_START) >> 3 : 64'd0;
    assign o_mem_wen   = w_store;
    assign o_mem_wmask = w_store ? w_lane_mask : 64'd0;
    assign o_mem_wdata = w_store ? r_wdata << w_shift : 64'd0;
    assign w_load_data = (i_mem_rdata >> w_shift) & w_size_mask;
    assign o_if_rvalid  = w_resp & ~r_src_lsu;
    assign o_lsu_rvalid = w_resp & r_src_lsu;
    assign w_if_data    = r_addr[2] ? i_mem_rdata[63:32] : i_mem_rdata[31:0];
    assign w_lsu_data   = r_wen ? 64'd0 : w_load_data;
    assign o_if_rdata   = o_if_rvalid ? w_if_data : r_if_rdata;
    assign o_lsu_rdata  = o_lsu_rvalid ? w_lsu_data : r_lsu_rdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_streak    <= 4'd0;
            r_src_lsu   <= 1'b0;
            r_wen       <= 1'b0;
            r_addr      <= 64'd0;
            r_size      <= 2'd0;
            r_wdata     <= 64'd0;
            r_if_rdata  <= 32'd0;
            r_lsu_rdata <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_streak <= (w_sel_lsu & i_if_req) ? r_streak + 4'd1 : 4'd0;
                    if (w_sel_lsu | w_sel_if) begin
                        r_state   <= ACCESS;
                        r_src_lsu <= w_sel_lsu;
                        r_wen     <= w_sel_lsu & i_lsu_wen;
                        r_addr    <= {w_req_addr[63:3], w_req_off};
                        r_size    <= w_req_size;
                        r_wdata   <= i_lsu_wdata;
                    end
                end
                ACCESS: r_state <= RESP;
                RESP: begin
                    r_state     <= IDLE;
                    r_if_rdata  <= o_if_rvalid ? w_if_data : r_if_rdata;
                    r_lsu_rdata <= o_lsu_rvalid ? w_lsu_data : r_lsu_rdata;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random transactions against a byte-array memory reference
module tb_mem_port_arbiter;
    localparam logic [63:0] PC = 64'h8000_0000;
    localparam int MAX = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic if_req = 1'b0, lsu_req = 1'b0, lsu_wen = 1'b0;
    logic [63:0] if_addr = '0, lsu_addr = '0, lsu_wdata = '0;
    logic [1:0] lsu_size = '0;
    logic if_ready, if_rvalid, lsu_ready, lsu_rvalid, mem_en, mem_wen;
    logic [31:0] if_rdata;
    logic [63:0] lsu_rdata, mem_idx, mem_wmask, mem_wdata, mem_rdata;
    logic [63:0] mem [0:31];
    logic init_we = 1'b0;
    logic [4:0] init_idx = '0;
    logic [63:0] init_val = '0;
    logic [7:0] ref_b [0:255];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.PC_START(PC), .MAX_LSU_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(if_ready),
        .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_lsu_req(lsu_req), .i_lsu_wen(lsu_wen), .i_lsu_addr(lsu_addr),
        .i_lsu_size(lsu_size), .i_lsu_wdata(lsu_wdata), .o_lsu_ready(lsu_ready),
        .o_lsu_rvalid(lsu_rvalid), .o_lsu_rdata(lsu_rdata),
        .o_mem_en(mem_en), .o_mem_idx(mem_idx), .o_mem_wen(mem_wen),
        .o_mem_wmask(mem_wmask), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // RAMHelper-style memory: read data appears the cycle after mem_en
    always @(posedge clk) begin
        if (init_we) mem[init_idx] <= init_val;
        else if (mem_en) begin
            mem_rdata <= mem[mem_idx[4:0]];
            if (mem_wen) mem[mem_idx[4:0]] <= (mem[mem_idx[4:0]] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    function automatic logic [63:0] ref_read(input int a, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = ref_b[a + i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge and follow it through accept, access, response and hold
    task automatic xact(input bit is_lsu, input bit wen, input logic [63:0] addr,
                        input logic [1:0] size, input logic [63:0] wdata, output int waited);
        int n, base, off, t;
        bit st;
        logic [63:0] em, ew, ed;
        n = is_lsu ? (1 << size) : 4;
        base = int'(addr - PC) & ~(n - 1);
        off = base % 8;
        st = is_lsu && wen;
        em = '0;
        for (int i = 0; i < n; i++) em[8*(off+i) +: 8] = 8'hFF;
        ew = wdata << (8 * off);
        ed = st ? 64'h0 : ref_read(base, n);
        if_req = !is_lsu; if_addr = addr;
        lsu_req = is_lsu; lsu_wen = wen; lsu_addr = addr; lsu_size = size; lsu_wdata = wdata;
        #1;
        t = 0;
        while (!(is_lsu ? lsu_ready : if_ready) && t < 20) begin
            @(negedge clk); #1; t++;
        end
        waited = t;
        chk("accept", is_lsu ? lsu_ready : if_ready, 1);
        chk("ready_excl", if_ready & lsu_ready, 0);
        @(negedge clk);
        if_req = 0; lsu_req = 0;
        #1;
        chk("mem_en", mem_en, 1);
        chk("mem_idx", mem_idx, base / 8);
        chk("mem_wen", mem_wen, st);
        chk("mem_wmask", mem_wmask, st ? em : 64'h0);
        if (st) begin
            chk("mem_wdata", mem_wdata, ew);
            for (int i = 0; i < n; i++) ref_b[base + i] = wdata[8*i +: 8];
        end
        chk("ready_busy", if_ready | lsu_ready, 0);
        @(negedge clk); #1;
        if (is_lsu) begin
            chk("lsu_rvalid", lsu_rvalid, 1);
            chk("lsu_rdata", lsu_rdata, ed);
        end else begin
            chk("if_rvalid", if_rvalid, 1);
            chk("if_rdata", if_rdata, ed);
        end
        chk("mem_en_resp", mem_en, 0);
        @(negedge clk); #1;
        chk("rvalid_pulse", if_rvalid | lsu_rvalid, 0);
        if (is_lsu) chk("lsu_hold", lsu_rdata, ed);
        else chk("if_hold", if_rdata, ed);
    endtask

    initial begin
        int w, g, c, r, sz;
        logic [63:0] a, d;
        for (int b = 0; b < 256; b++) ref_b[b] = 8'($urandom);
        d = 64'hAAAA_BBBB_1111_2222;
        for (int i = 0; i < 8; i++) ref_b[i] = d[8*i +: 8];
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            init_we = 1; init_idx = 5'(i); init_val = ref_read(8 * i, 8);
        end
        @(negedge clk); init_we = 0;
        @(negedge clk); #1;
        chk("rst_if_ready", if_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_mem_idx", mem_idx, 0);
        chk("rst_rvalid", if_rvalid | lsu_rvalid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_lsu_rdata", lsu_rdata, 0);
        rst = 0;

        xact(0, 0, PC + 64'h4, 2'd0, 64'h0, w);
        chk("if_literal", if_rdata, 64'hAAAA_BBBB);
        xact(1, 1, PC + 64'h13, 2'd0, 64'h5A, w);
        xact(1, 0, PC + 64'h10, 2'd3, 64'h0, w);
        chk("merged_byte", lsu_rdata[31:24], 8'h5A);
        xact(1, 1, PC, 2'd3, 64'h1234_5678_9ABC_DEF0, w);
        xact(1, 0, PC + 64'h6, 2'd1, 64'h0, w);
        chk("half_literal", lsu_rdata, 64'h1234);

        // Contention: both held high, LSU wins MAX times then IF gets one grant
        if_req = 1; if_addr = PC + 64'h8;
        lsu_req = 1; lsu_wen = 0; lsu_addr = PC + 64'h10; lsu_size = 2'd3;
        #1;
        g = 0; c = 0;
        while (g < 10 && c < 100) begin
            if (c > 0) begin @(negedge clk); #1; end
            chk("cont_excl", if_ready & lsu_ready, 0);
            if (if_ready | lsu_ready) begin
                chk("cont_grant_if", if_ready, (g % (MAX + 1)) == MAX);
                g++;
            end
            c++;
        end
        chk("cont_grants", g, 10);
        @(negedge clk); if_req = 0; lsu_req = 0;
        @(negedge clk);
        @(negedge clk); #1;

        // Back-to-back: LSU waits behind an IF access and is accepted 3 cycles after it
        if_req = 1; if_addr = PC + 64'h20; #1;
        chk("b2b_if_ready", if_ready, 1);
        @(negedge clk);
        if_req = 0; lsu_req = 1; lsu_wen = 0; lsu_addr = PC + 64'h28; lsu_size = 2'd2; #1;
        chk("b2b_wait1", lsu_ready, 0);
        @(negedge clk); #1;
        chk("b2b_wait2", lsu_ready, 0);
        chk("b2b_if_rvalid", if_rvalid, 1);
        chk("b2b_if_rdata", if_rdata, ref_read(32'h20, 4));
        @(negedge clk); #1;
        chk("b2b_lsu_ready", lsu_ready, 1);
        @(negedge clk); lsu_req = 0;
        @(negedge clk); #1;
        chk("b2b_lsu_rvalid", lsu_rvalid, 1);
        chk("b2b_lsu_rdata", lsu_rdata, ref_read(32'h28, 4));
        @(negedge clk); #1;

        // Reset while a store is in ACCESS
        d = {$urandom, $urandom};
        lsu_req = 1; lsu_wen = 1; lsu_addr = PC + 64'h30; lsu_size = 2'd2; lsu_wdata = d; #1;
        chk("rst_store_ready", lsu_ready, 1);
        @(negedge clk);
        lsu_req = 0; rst = 1; #1;
        chk("rst_store_mem_en", mem_en, 1);
        for (int i = 0; i < 4; i++) ref_b[8'h30 + i] = d[8*i +: 8];
        @(negedge clk);
        rst = 0; #1;
        chk("rst_mid_mem_en", mem_en, 0);
        chk("rst_mid_mem_wen", mem_wen, 0);
        chk("rst_mid_rvalid", lsu_rvalid, 0);
        chk("rst_mid_rdata", lsu_rdata, 0);
        xact(1, 0, PC + 64'h30, 2'd2, 64'h0, w);
        chk("rst_accept_now", w, 0);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 2);
            sz = $urandom_range(0, 3);
            a = PC + 64'($urandom_range(0, 255));
            d = {$urandom, $urandom};
            if (r == 0) xact(0, 0, PC + 64'(4 * $urandom_range(0, 63)), 2'd0, 64'h0, w);
            else xact(1, r == 2, a, 2'(sz), d, w);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
